// File: rtl/wb_write_queue.sv
// Write-back request queue feeding the register file write port; optional forwarding scan under `WBQ_FORWARD_EN`.
// Latency: a push at edge N presents on rf_we/write_reg/write_data during cycle N+1.
// Backpressure: in_ready drops only when full (registered count); rf_ready=0 holds the head entry stable.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_reg,
    input  logic [DW-1:0]          in_data,
    output logic                   rf_we,
    input  logic                   rf_ready,
    output logic [AW-1:0]          write_reg,
    output logic [DW-1:0]          write_data,
    input  logic [AW-1:0]          rd_addr,
    output logic                   rd_hit,
    output logic [DW-1:0]          rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] reg_q  [DEPTH];
    logic [AW-1:0] reg_d  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic push_en, pop_en;

    assign in_ready   = (count_q != CW'(DEPTH));
    assign rf_we      = (count_q != '0);
    assign write_reg  = reg_q[head_q];
    assign write_data = data_q[head_q];
    assign count      = count_q;

    always_comb begin
        reg_d   = reg_q;
        data_d  = data_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Register 0 is hardwired zero: the handshake completes but nothing is stored.
        push_en = in_valid && in_ready && (in_reg != '0);
        pop_en  = rf_we && rf_ready;
        if (push_en) begin
            reg_d[tail_q]  = in_reg;
            data_d[tail_q] = in_data;
            vld_d[tail_q]  = 1'b1;
            tail_d         = tail_q + PW'(1);
        end
        if (pop_en) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        if (push_en && !pop_en) begin
            count_d = count_q + CW'(1);
        end else if (!push_en && pop_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            reg_q   <= reg_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef WBQ_FORWARD_EN
    logic [PW-1:0] fwd_idx;

    // Walk oldest to newest from the head so the newest match overwrites older ones.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        fwd_idx = head_q;
        if (rd_addr != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = head_q + PW'(i);
                if (vld_q[fwd_idx] && (reg_q[fwd_idx] == rd_addr)) begin
                    rd_hit  = 1'b1;
                    rd_data = data_q[fwd_idx];
                end
            end
        end
    end
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^rd_addr;
    assign rd_hit         = 1'b0;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue; forwarding expectations follow WBQ_FORWARD_EN.
module tb_wb_write_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg;
    logic [31:0] in_data;
    logic        rf_we;
    logic        rf_ready;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic [3:0]  rd_addr;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    wb_write_queue #(.DEPTH(4), .AW(4), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .rf_we(rf_we), .rf_ready(rf_ready), .write_reg(write_reg), .write_data(write_data),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [31:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_fwd(input string tag, input logic [3:0] a, input logic hit, input logic [31:0] d);
        rd_addr = a;
        #1;
`ifdef WBQ_FORWARD_EN
        chk({tag, "_hit"}, 32'(rd_hit), 32'(hit));
        chk({tag, "_data"}, rd_data, d);
`else
        chk({tag, "_hit"}, 32'(rd_hit), 32'd0);
        chk({tag, "_data"}, rd_data, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0; rf_ready = 1'b0; rd_addr = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_write_reg", 32'(write_reg), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_rd_hit", 32'(rd_hit), 32'd0);
        step();
        rst_n = 1'b1;

        // Basic flow
        rf_ready = 1'b1;
        push(4'd3, 32'hDEADBEEF);
        chk("basic_rf_we", 32'(rf_we), 32'd1);
        chk("basic_reg", 32'(write_reg), 32'd3);
        chk("basic_data", write_data, 32'hDEADBEEF);
        chk("basic_count1", 32'(count), 32'd1);
        step();
        chk("basic_count0", 32'(count), 32'd0);
        chk("basic_rf_we0", 32'(rf_we), 32'd0);

        // Fill and stall: fifth request refused
        rf_ready = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            in_valid = 1'b1; in_reg = 4'(r); in_data = 32'h100 + 32'(r);
            #1;
            chk($sformatf("fill_rdy%0d", r), 32'(in_ready), (r <= 4) ? 32'd1 : 32'd0);
            step();
        end
        in_valid = 1'b0;
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_head_stable", 32'(write_reg), 32'd1);
        rf_ready = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            chk($sformatf("drain_reg%0d", r), 32'(write_reg), 32'(r));
            chk($sformatf("drain_data%0d", r), write_data, 32'h100 + 32'(r));
            step();
        end
        chk("drain_count", 32'(count), 32'd0);

        // Full with simultaneous pop
        rf_ready = 1'b0;
        for (int r = 1; r <= 4; r++) push(4'(r), 32'h200 + 32'(r));
        in_valid = 1'b1; in_reg = 4'd6; in_data = 32'h66; rf_ready = 1'b1;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("full_count3", 32'(count), 32'd3);
        chk("full_in_ready1", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("full_count_keep3", 32'(count), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("full_drain%0d", k), 32'(write_reg), (k == 2) ? 32'd6 : 32'(k + 3));
            step();
        end
        chk("full_drained", 32'(count), 32'd0);

        // Register 0 drop
        push(4'd0, 32'h1234);
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_rf_we", 32'(rf_we), 32'd0);
        push(4'd7, 32'h55);
        chk("r7_count", 32'(count), 32'd1);
        chk("r7_reg", 32'(write_reg), 32'd7);
        chk("r7_data", write_data, 32'h55);
        step();
        chk("r7_count0", 32'(count), 32'd0);

        // Forwarding
        rf_ready = 1'b0;
        push(4'd5, 32'hA);
        push(4'd9, 32'hB);
        push(4'd5, 32'hC);
        chk("fwd_count", 32'(count), 32'd3);
        chk_fwd("fwd5", 4'd5, 1'b1, 32'hC);
        chk_fwd("fwd9", 4'd9, 1'b1, 32'hB);
        chk_fwd("fwd2", 4'd2, 1'b0, 32'h0);
        chk_fwd("fwd0", 4'd0, 1'b0, 32'h0);
        in_valid = 1'b1; in_reg = 4'd2; in_data = 32'h77;
        chk_fwd("fwd_inflight", 4'd2, 1'b0, 32'h0);
        in_valid = 1'b0;

        // Reset mid-operation, asserted between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_rf_we", 32'(rf_we), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_rd_hit", 32'(rd_hit), 32'd0);
        step();
        rst_n = 1'b1;
        rf_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post_rst_rf_we%0d", k), 32'(rf_we), 32'd0);
            step();
        end
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_write_reg", 32'(write_reg), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Write-back request queue that sits directly upstream of the 16 x 32-bit register file write port (`write_reg` [3:0], `write_data` [31:0]). It buffers register write requests from the execute/write-back path in a small FIFO and drains them in order into the register file, one per cycle, honouring a register-file stall. An optional forwarding port lets readers see the newest still-queued value for a register before it lands in the register file.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `AW`, 4: register address width, matching `write_reg`.
- `DW`, 32: data width, matching `write_data`.

Ports:
- `clk`  in  1  Single clock; all state changes on its rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `in_valid`  in  1  Upstream write request present.
- `in_ready`  out  1  Queue can accept a request this cycle.
- `in_reg`  in  AW  Destination register of the request.
- `in_data`  in  DW  Data for the request.
- `rf_we`  out  1  Write strobe to the register file; high whenever the queue is non-empty.
- `rf_ready`  in  1  Register file accepts the write this cycle.
- `write_reg`  out  AW  Head entry address, to the register file.
- `write_data`  out  DW  Head entry data, to the register file.
- `rd_addr`  in  AW  Forwarding lookup address.
- `rd_hit`  out  1  A queued entry matches `rd_addr`.
- `rd_data`  out  DW  Data of the newest matching queued entry.
- `count`  out  $clog2(DEPTH)+1  Number of occupied entries.

## Operation
- Storage: circular buffer of DEPTH entries {reg, data, valid}, with head and tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus an occupancy counter.
- Push: occurs when `in_valid && in_ready`. The entry is written at the tail, and the tail and count increment.
- Register 0 filter: a handshake with `in_reg == 0` completes normally, but nothing is enqueued. Register 0 is hardwired zero.
- `in_ready = (count != DEPTH)`. It depends only on the registered count, not on same-cycle pop. A full queue refuses a push even while popping.
- Pop: occurs when `rf_we && rf_ready`. The head entry is retired, the head increments and the count decrements.
- `rf_we = (count != 0)`. `write_reg`/`write_data` show the head entry combinationally from storage.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
- Empty with `rf_ready = 1`: no pop, `rf_we = 0`, and `write_reg`/`write_data` hold stale storage content.
- Forwarding: combinational scan of occupied entries only. The entry closest to the tail (newest) with `reg == rd_addr` wins. The in-flight `in_*` request is not visible. If `rd_addr == 0`, then `rd_hit = 0` and `rd_data = 0`.
- If nothing matches: `rd_hit = 0` and `rd_data = 0`.
- Reset mid-operation: all queued entries are discarded with no register-file writes. Pointers and count clear immediately (asynchronously).

## Timing
- Reset values:
  - `in_ready = 1`, `rf_we = 0`, `count = 0`.
  - `write_reg = 0`, `write_data = 0`: storage clears on reset.
  - `rd_hit = 0`, `rd_data = 0`.
- Latency: a request pushed at edge N drives `rf_we` with its data during cycle N+1. With `rf_ready` held high it retires at edge N+1.
- Throughput: one push and one pop per cycle when neither full nor empty.
- Stall: while `rf_ready = 0`, `rf_we`, `write_reg` and `write_data` stay stable, and pushes continue until full.
- Timing path: `rd_hit`/`rd_data` are combinational from `rd_addr` and registered state. `in_ready` and `rf_we` have no combinational path from any input.
- Reset deassertion: `rst_n` must be released synchronously to `clk` by the system reset synchroniser.

## Configuration
- `WBQ_FORWARD_EN`:
  - Defined: the forwarding scan is built as described.
  - Undefined: `rd_hit` and `rd_data` are tied to 0, no compare logic is generated, and the `rd_addr` input is ignored. Queue behaviour is otherwise identical.

## Test plan
- Basic flow: reset, `rf_ready = 1`, push (reg 3, 0xDEADBEEF) at edge 1. Expect `rf_we = 1`, `write_reg = 3`, `write_data = 0xDEADBEEF` in cycle 2; `count` returns to 0 after edge 2.
- Fill and stall: `rf_ready = 0`, push regs 1..5 on consecutive cycles. Expect the first 4 accepted, `in_ready = 0` and `count = 4`; then `rf_ready = 1` drains regs 1,2,3,4 in order, one per cycle.
- Full with simultaneous pop: full queue, `in_valid = 1`, `rf_ready = 1`. Expect the push refused that cycle, `count = 3` next, and the push accepted the following cycle.
- Register 0 drop: push (reg 0, 0x1234), then (reg 7, 0x55). Expect only reg 7 to appear on `rf_we`, with `count` peaking at 1.
- Forwarding (`WBQ_FORWARD_EN`): `rf_ready = 0`, queue (reg 5, 0xA), (reg 9, 0xB), (reg 5, 0xC); `rd_addr = 5`. Expect `rd_hit = 1`, `rd_data = 0xC`. With `rd_addr = 2`, expect `rd_hit = 0`. With the macro undefined, expect `rd_hit = 0` always.
- Reset mid-operation: 3 entries queued, `rst_n` low for 1 cycle. Expect `count = 0`, `rf_we = 0` and `in_ready = 1` immediately, and no stale write after release.
